// File: rtl/strided_ring_counter.sv
// strided_ring_counter: ring/Johnson sequencer spread across a strided select bus
module strided_ring_counter #(
   parameter int POSITIONS = 5,
   parameter int STRIDE    = 3,
   parameter int OFFSET    = 2,
   parameter int RESET_POS = 4,
   localparam int PH_W     = $clog2(2 * POSITIONS),
   localparam int OUT_W    = POSITIONS * STRIDE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             dir,
   input  logic             mode,
   input  logic             load,
   input  logic [PH_W-1:0]  load_pos,
   input  logic             clear,
   output logic [OUT_W-1:0] out,
   output logic [PH_W-1:0]  pos,
   output logic             wrap,
   output logic             load_err
);
   if (POSITIONS < 2 || STRIDE < 1 || OFFSET < 0 || OFFSET >= STRIDE || RESET_POS < 0 || RESET_POS >= POSITIONS) begin : g_bad_params
      $error("strided_ring_counter: parameter out of range");
   end
   localparam logic [PH_W-1:0]      N_PH      = PH_W'(POSITIONS);
   localparam logic [PH_W-1:0]      RING_LAST = PH_W'(POSITIONS - 1);
   localparam logic [PH_W-1:0]      JOHN_LAST = PH_W'(2 * POSITIONS - 1);
   localparam logic [PH_W-1:0]      RST_PH    = PH_W'(RESET_POS);
   localparam logic [PH_W-1:0]      PH_ONE    = PH_W'(1);
   localparam logic [POSITIONS-1:0] RING_RST  = POSITIONS'(1) << RESET_POS;
   logic                 mode_q, mode_d;
   logic [POSITIONS-1:0] cell_q, cell_d, load_cell;
   logic [PH_W-1:0]      pos_q, pos_d, last;
   logic                 wrap_q, wrap_d, load_err_q, load_err_d;
   logic                 legal, load_ok;
   // Decode the current phase range, state legality and the pattern a load would install
   always_comb begin
      last      = mode_q ? JOHN_LAST : RING_LAST;
      legal     = mode_q ? $onehot0(cell_q[POSITIONS-2:0] ^ cell_q[POSITIONS-1:1]) : $onehot(cell_q);
      load_ok   = load_pos <= last;
      load_cell = '0;
      for (int i = 0; i < POSITIONS; i++)
         load_cell[i] = mode_q ? (load_pos <= N_PH ? PH_W'(i) < load_pos : PH_W'(i) >= load_pos - N_PH)
                               : load_pos == PH_W'(i);
   end
   // Next state: recovery/clear > mode change > load > step
   always_comb begin
      mode_d     = mode_q;
      cell_d     = cell_q;
      pos_d      = pos_q;
      wrap_d     = 1'b0;
      load_err_d = 1'b0;
      if (!legal || clear) begin
         cell_d = mode_q ? '0 : RING_RST;
         pos_d  = mode_q ? '0 : RST_PH;
      end else if (mode != mode_q) begin
         mode_d = mode;
         cell_d = mode ? '0 : RING_RST;
         pos_d  = mode ? '0 : RST_PH;
      end else if (load) begin
         cell_d     = load_ok ? load_cell : cell_q;
         pos_d      = load_ok ? load_pos : pos_q;
         load_err_d = !load_ok;
      end else if (start) begin
         cell_d = dir ? {cell_q[0] ^ mode_q, cell_q[POSITIONS-1:1]}
                      : {cell_q[POSITIONS-2:0], cell_q[POSITIONS-1] ^ mode_q};
         pos_d  = dir ? (pos_q == '0 ? last : pos_q - PH_ONE)
                      : (pos_q == last ? '0 : pos_q + PH_ONE);
         wrap_d = dir ? pos_q == '0 : pos_q == last;
      end
   end
   // State registers with asynchronous reset to the ring reset pattern
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q     <= 1'b0;
         cell_q     <= RING_RST;
         pos_q      <= RST_PH;
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         cell_q     <= cell_d;
         pos_q      <= pos_d;
         wrap_q     <= wrap_d;
         load_err_q <= load_err_d;
      end
   end
   // Spread each cell onto its lane of the strided bus; other lanes stay low
   always_comb begin
      out = '0;
      for (int i = 0; i < POSITIONS; i++)
         out[i*STRIDE+OFFSET] = cell_q[i];
   end
   assign pos      = pos_q;
   assign wrap     = wrap_q;
   assign load_err = load_err_q;
endmodule

// File: tb/tb_strided_ring_counter.sv
// tb_strided_ring_counter: directed checks of the strided ring/Johnson sequencer
module tb_strided_ring_counter;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, dir = 1'b0, mode = 1'b0, load = 1'b0, clear = 1'b0;
   logic [3:0]  load_pos = 4'd0;
   logic [14:0] out;
   logic [3:0]  pos;
   logic        wrap, load_err;
   logic        start8 = 1'b0;
   logic [7:0]  out8;
   logic [3:0]  pos8;
   logic        wrap8, load_err8;
   int          n_chk = 0, n_fail = 0;
   int          rf [5]  = '{'h0004, 'h0020, 'h0100, 'h0800, 'h4000};
   int          jf [10] = '{'h0000, 'h0004, 'h0024, 'h0124, 'h0924, 'h4924, 'h4920, 'h4900, 'h4800, 'h4000};

   always #5 clk = ~clk;

   strided_ring_counter dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .mode(mode), .load(load),
      .load_pos(load_pos), .clear(clear), .out(out), .pos(pos), .wrap(wrap), .load_err(load_err)
   );

   strided_ring_counter #(.POSITIONS(8), .STRIDE(1), .OFFSET(0), .RESET_POS(0)) u8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .dir(1'b0), .mode(1'b0), .load(1'b0),
      .load_pos(4'd0), .clear(1'b0), .out(out8), .pos(pos8), .wrap(wrap8), .load_err(load_err8)
   );

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic st(input string tag, input int o, input int p, input int w);
      chk({tag, " out"}, 32'(out), o);
      chk({tag, " pos"}, 32'(pos), p);
      chk({tag, " wrap"}, 32'(wrap), w);
   endtask

   initial begin
      #12;
      st("reset", 'h4000, 4, 0);
      chk("reset load_err", 32'(load_err), 0);
      chk("reset out8", 32'(out8), 1);
      rst_n = 1'b1;
      start = 1'b1;
      cyc; st("t1 step1", 'h0004, 0, 1);
      start = 1'b0;
      cyc; st("t1 hold", 'h0004, 0, 0);
      start = 1'b1;
      for (int i = 1; i < 5; i++) begin
         cyc; st("t1 fwd", rf[i], i, 0);
      end
      dir = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         cyc; st("t2 rev", rf[i], i, 0);
      end
      cyc; st("t2 rev wrap", 'h4000, 4, 1);
      start = 1'b0;
      cyc; st("t2 idle", 'h4000, 4, 0);
      mode = 1'b1; start = 1'b1; dir = 1'b0;
      cyc; st("t3 mode", 0, 0, 0);
      for (int i = 1; i <= 10; i++) begin
         cyc; st("t3 john", jf[i%10], i % 10, (i == 10) ? 1 : 0);
      end
      dir = 1'b1;
      cyc; st("t3 jrev wrap", 'h4000, 9, 1);
      dir = 1'b0; start = 1'b0; load = 1'b1; load_pos = 4'd7;
      cyc; st("t4 jload7", 'h4900, 7, 0);
      chk("t4 jload7 err", 32'(load_err), 0);
      load_pos = 4'd3;
      cyc; st("t4 jload3", 'h0124, 3, 0);
      load_pos = 4'd10;
      cyc; st("t4 jload10", 'h0124, 3, 0);
      chk("t4 jload10 err", 32'(load_err), 1);
      load_pos = 4'd9;
      cyc; st("t4 jload9", 'h4000, 9, 0);
      chk("t4 jload9 err", 32'(load_err), 0);
      load = 1'b0; mode = 1'b0;
      cyc; st("t4 ring rst", 'h4000, 4, 0);
      load = 1'b1; load_pos = 4'd2; start = 1'b1;
      cyc; st("t4 rload2", 'h0100, 2, 0);
      load_pos = 4'd5;
      cyc; st("t4 rload5", 'h0100, 2, 0);
      chk("t4 rload5 err", 32'(load_err), 1);
      clear = 1'b1; load_pos = 4'd1;
      cyc; st("t5 clear", 'h4000, 4, 0);
      chk("t5 clear err", 32'(load_err), 0);
      mode = 1'b1;
      cyc; st("t5 clr over mode", 'h4000, 4, 0);
      clear = 1'b0; load = 1'b0; mode = 1'b0;
      cyc; st("t5 step", 'h0004, 0, 1);
      start = 1'b0;
      #2 rst_n = 1'b0;
      #1 st("t5 async", 'h4000, 4, 0);
      #3 rst_n = 1'b1;
      start = 1'b1;
      cyc; st("t5 post rst", 'h0004, 0, 1);
      start = 1'b0;
      chk("t6 reset out8", 32'(out8), 1);
      chk("t6 reset pos8", 32'(pos8), 0);
      start8 = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         cyc;
         chk("t6 out8", 32'(out8), 1 << (i % 8));
         chk("t6 pos8", 32'(pos8), i % 8);
         chk("t6 wrap8", 32'(wrap8), (i == 8) ? 1 : 0);
      end
      start8 = 1'b0;
      cyc;
      chk("t6 idle wrap8", 32'(wrap8), 0);
      chk("t6 idle out8", 32'(out8), 1);
      chk("t6 load_err8", 32'(load_err8), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
